fft_bitrev_buffer: RTL and testbench

Input reorder stage placed directly upstream of the `dit` FFT core. It accepts complex samples in natural order, one frame of N samples at a time, and replays each frame in bit-reversed index order, which is the order a decimation-in-time core expects. A ping-pong pair of frame buffers lets the next frame be written while the previous one is read out. Per-sample metadata travels with its sample, and frame and overflow status are reported in the same style as the `dit` core so the two blocks chain directly.

---
 rtl/fft_bitrev_buffer.sv | 113 +++++++++++
 tb/tb_fft_bitrev_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong frame buffer that replays natural-order frames in bit-reversed index order.
// Latency: frame's last sample accepted at edge E -> output index 0 valid after edge E+2.
// Backpressure: none; output cannot stall, and a sample arriving at a full bank is dropped and flags error.
module fft_bitrev_buffer #(
   parameter int N       = 8,
   parameter int LOG_N   = 3,
   parameter int X_WIDTH = 16,
   parameter int MWIDTH  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*X_WIDTH-1:0] in_data,
   input  logic                 in_nd,
   input  logic [MWIDTH-1:0]    in_m,
   output logic [2*X_WIDTH-1:0] out_data,
   output logic                 out_nd,
   output logic [MWIDTH-1:0]    out_m,
   output logic                 first,
   output logic                 error
);

   typedef enum logic {IDLE, READ} rd_state_t;

   function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
      logic [LOG_N-1:0] r;
      for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
      return r;
   endfunction

   logic [2*X_WIDTH-1:0] mem_d [0:2*N-1];
   logic [MWIDTH-1:0]    mem_m [0:2*N-1];

   rd_state_t        state;
   logic [1:0]       full;
   logic [1:0]       full_nxt;
   logic             wr_bank;
   logic             rd_bank;
   logic [LOG_N-1:0] wr_addr;
   logic [LOG_N-1:0] rd_addr;
   logic             wr_en;
   logic             wr_last;
   logic             rd_en;
   logic             rd_last;
   logic [LOG_N:0]   rd_idx;

   assign wr_en   = in_nd && !full[wr_bank];
   assign wr_last = wr_en && (wr_addr == LOG_N'(N-1));
   assign rd_en   = (state == READ);
   assign rd_last = rd_en && (rd_addr == LOG_N'(N-1));
   assign rd_idx  = {rd_bank, bitrev(rd_addr)};

   // Write and read always act on different banks: a completing write needs
   // its bank empty, a finishing read needs its bank full.
   always_comb begin
      full_nxt = full;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_d[{wr_bank, wr_addr}] <= in_data;
         mem_m[{wr_bank, wr_addr}] <= in_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_addr  <= '0;
         rd_addr  <= '0;
         out_data <= '0;
         out_m    <= '0;
         out_nd   <= 1'b0;
         first    <= 1'b0;
         error    <= 1'b0;
      end else begin
         full <= full_nxt;
         if (in_nd && full[wr_bank]) error <= 1'b1;
         if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
            if (wr_last) wr_bank <= ~wr_bank;
         end

         out_nd <= rd_en;
         first  <= rd_en && (rd_addr == '0);
         if (rd_en) begin
            out_data <= mem_d[rd_idx];
            out_m    <= mem_m[rd_idx];
         end

         case (state)
            IDLE: begin
               rd_addr <= '0;
               if (full[rd_bank]) state <= READ;
            end
            READ: begin
               rd_addr <= rd_addr + 1'b1;
               if (rd_last) begin
                  rd_bank <= ~rd_bank;
                  // Includes a frame completing on this same edge, so frames chain gap-free.
                  if (!full_nxt[~rd_bank]) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Directed bench for fft_bitrev_buffer: expected samples queued as frames are driven, compared as output emerges.
module tb_fft_bitrev_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_nd;
   logic [0:0]  in_m;
   logic [31:0] out_data;
   logic        out_nd;
   logic [0:0]  out_m;
   logic        first;
   logic        error;

   typedef struct packed {
      logic [31:0] d;
      logic        m;
      logic        f;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   run_len = 0;
   int   last_run = 0;

   fft_bitrev_buffer #(.N(8), .LOG_N(3), .X_WIDTH(16), .MWIDTH(1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
      .out_data(out_data), .out_nd(out_nd), .out_m(out_m), .first(first), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] br3(input logic [2:0] a);
      return {a[0], a[1], a[2]};
   endfunction

   function automatic logic [31:0] mk(input logic [15:0] v);
      return {v, v ^ 16'h5A5A};
   endfunction

   // Output monitor: pops the scoreboard and tracks contiguous out_nd runs.
   always @(negedge clk) begin
      if (first && !out_nd) chk("first_without_nd", 1, 0);
      if (out_nd) begin
         run_len++;
         if (q.size() == 0) begin
            chk("unexpected_output", {32'd0, out_data}, 64'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", {32'd0, out_data}, {32'd0, e.d});
            chk("out_m",    {63'd0, out_m},    {63'd0, e.m});
            chk("first",    {63'd0, first},    {63'd0, e.f});
         end
      end else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int base);
      for (int k = 0; k < 8; k++) begin
         logic [2:0] idx;
         exp_t e;
         idx = br3(3'(k));
         e.d = mk(16'(base + int'(idx)));
         e.m = idx[0];
         e.f = (k == 0);
         q.push_back(e);
      end
   endtask

   task automatic send_frame(input int base, input bit gap);
      push_frame(base);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] ii;
         ii      = 3'(i);
         in_nd   = 1'b1;
         in_data = mk(16'(base + i));
         in_m    = ii[0];
         step();
         if (gap) begin
            in_nd = 1'b0;
            step();
         end
      end
      in_nd = 1'b0;
   endtask

   task automatic drain(input string tag);
      int cnt = 0;
      while ((q.size() != 0 || out_nd) && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      @(negedge clk);
      chk(tag, q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; in_nd = 1'b0; in_data = '0; in_m = '0;
      step(); step();
      @(negedge clk);
      chk("rst_out_nd",   {63'd0, out_nd}, 0);
      chk("rst_first",    {63'd0, first},  0);
      chk("rst_error",    {63'd0, error},  0);
      chk("rst_out_data", {32'd0, out_data}, 0);
      chk("rst_out_m",    {63'd0, out_m},  0);
      step();
      rst = 1'b0;
      step();

      // single frame, latency from last accepted sample
      send_frame(0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_e1_nd", {63'd0, out_nd}, 0);
      @(negedge clk);
      chk("lat_e2_nd",    {63'd0, out_nd}, 1);
      chk("lat_e2_first", {63'd0, first},  1);
      drain("t1_drain");
      chk("t1_run", last_run, 8);

      // two back-to-back frames
      send_frame(0, 1'b0);
      send_frame(8, 1'b0);
      drain("t2_drain");
      chk("t2_run", last_run, 16);
      chk("t2_error", {63'd0, error}, 0);

      // gapped input
      send_frame(16'h20, 1'b1);
      @(negedge clk);
      chk("gap_e1_nd", {63'd0, out_nd}, 0);
      @(negedge clk);
      chk("gap_e2_first", {63'd0, first}, 1);
      drain("t3_drain");
      chk("t3_run", last_run, 8);

      // frame 2 completes on the edge that frees frame 1's bank
      send_frame(16'h30, 1'b0);
      step();
      send_frame(16'h38, 1'b0);
      drain("t4_drain");
      chk("t4_run", last_run, 16);
      chk("t4_error", {63'd0, error}, 0);

      // overflow: extra sample arrives while both banks are full
      send_frame(16'h50, 1'b0);
      send_frame(16'h58, 1'b0);
      chk("ovf_pre_error", {63'd0, error}, 0);
      in_nd = 1'b1; in_data = mk(16'hAA); in_m = 1'b1;
      step();
      in_nd = 1'b0;
      chk("ovf_error", {63'd0, error}, 1);
      drain("t5_drain");
      chk("t5_run", last_run, 16);
      send_frame(16'h60, 1'b0);
      drain("t5b_drain");
      chk("t5b_run", last_run, 8);
      chk("ovf_error_sticky", {63'd0, error}, 1);

      // asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) begin
         in_nd = 1'b1; in_data = mk(16'(16'h70 + i)); in_m = 1'(i);
         step();
      end
      in_nd = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_out_data", {32'd0, out_data}, 0);
      chk("arst_error",    {63'd0, error},  0);
      chk("arst_out_nd",   {63'd0, out_nd}, 0);
      chk("arst_first",    {63'd0, first},  0);
      chk("arst_out_m",    {63'd0, out_m},  0);
      step(); step();
      rst = 1'b0;
      step();
      send_frame(16'h80, 1'b0);
      drain("t6_drain");
      chk("t6_run", last_run, 8);
      chk("t6_error", {63'd0, error}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
